// File: rtl/sr_lsu.sv
// Load/store unit: turns the decoder's memory strobes into one req/ack bus transaction per access,
// stalls the core while it runs and returns lane-extracted, extended load data.
module sr_lsu #(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned TIMEOUT = 15,
    parameter int unsigned TO_W    = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              dmRe,
    input  logic              dmWe,
    input  logic              dmSign,
    input  logic              dmOpByte,
    input  logic              dmOpHalf,
    input  logic              dmOpWord,
    input  logic [ADDR_W-1:0] dmAddr,
    input  logic [31:0]       dmDataW,
    output logic [31:0]       dmDataR,
    output logic              stall,
    output logic              dmMisalign,
    output logic              dmBusErr,
    output logic              busReq,
    output logic              busWe,
    output logic [ADDR_W-1:0] busAddr,
    output logic [3:0]        busBe,
    output logic [31:0]       busWData,
    input  logic [31:0]       busRData,
    input  logic              busAck
);

    typedef enum logic [1:0] {StIdle, StReq, StResp} state_e;

    state_e            state_q, state_d;
    logic [TO_W-1:0]   cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [3:0]        be_q, be_d;
    logic              we_q, we_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [1:0]        off_q, off_d;
    logic              byte_q, byte_d, half_q, half_d, sign_q, sign_d;
    logic [31:0]       data_q, data_d;
    logic              err_q, err_d;

    logic        op_byte, op_half, op_word, access, mis, go, timeout;
    logic [3:0]  be_in;
    logic [31:0] wd_in, ld_ext;
    logic [7:0]  ld_b;
    logic [15:0] ld_h;

    // Byte beats half beats word; no strobe at all means word.
    assign op_byte = dmOpByte;
    assign op_half = ~dmOpByte & dmOpHalf;
    assign op_word = ~op_byte & ~op_half;
    assign access  = dmRe | dmWe;
    assign mis     = access & ((op_half & dmAddr[0]) | (op_word & (dmAddr[1:0] != 2'b00)));
    assign go      = access & ~mis;
    assign timeout = (cnt_q == TO_W'(TIMEOUT - 1));

    always_comb begin
        be_in = 4'b1111;
        wd_in = dmDataW;
        if (op_byte) begin
            be_in = 4'b0001 << dmAddr[1:0];
            wd_in = {4{dmDataW[7:0]}};
        end else if (op_half) begin
            be_in = dmAddr[1] ? 4'b1100 : 4'b0011;
            wd_in = {2{dmDataW[15:0]}};
        end
    end

    always_comb begin
        ld_b   = busRData[{off_q, 3'b000} +: 8];
        ld_h   = off_q[1] ? busRData[31:16] : busRData[15:0];
        ld_ext = busRData;
        if (byte_q) begin
            ld_ext = {{24{sign_q & ld_b[7]}}, ld_b};
        end else if (half_q) begin
            ld_ext = {{16{sign_q & ld_h[15]}}, ld_h};
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        be_d    = be_q;
        we_d    = we_q;
        wdata_d = wdata_q;
        off_d   = off_q;
        byte_d  = byte_q;
        half_d  = half_q;
        sign_d  = sign_q;
        data_d  = data_q;
        err_d   = err_q;
        unique case (state_q)
            StIdle: begin
                if (go) begin
                    addr_d  = {dmAddr[ADDR_W-1:2], 2'b00};
                    be_d    = be_in;
                    we_d    = dmWe;
                    wdata_d = wd_in;
                    off_d   = dmAddr[1:0];
                    byte_d  = op_byte;
                    half_d  = op_half;
                    sign_d  = dmSign;
                    cnt_d   = '0;
                    err_d   = 1'b0;
                    state_d = StReq;
                end
            end
            StReq: begin
                // Ack wins over a timeout landing on the same cycle.
                if (busAck) begin
                    if (!we_q) data_d = ld_ext;
                    err_d   = 1'b0;
                    state_d = StResp;
                end else if (timeout) begin
                    if (!we_q) data_d = '0;
                    err_d   = 1'b1;
                    state_d = StResp;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StResp:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            addr_q  <= '0;
            be_q    <= '0;
            we_q    <= 1'b0;
            wdata_q <= '0;
            off_q   <= '0;
            byte_q  <= 1'b0;
            half_q  <= 1'b0;
            sign_q  <= 1'b0;
            data_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            be_q    <= be_d;
            we_q    <= we_d;
            wdata_q <= wdata_d;
            off_q   <= off_d;
            byte_q  <= byte_d;
            half_q  <= half_d;
            sign_q  <= sign_d;
            data_q  <= data_d;
            err_q   <= err_d;
        end
    end

    assign busReq     = (state_q == StReq);
    assign stall      = ((state_q == StIdle) & go) | busReq;
    assign dmMisalign = mis;
    // A misaligned load reads back zero without touching the bus.
    assign dmDataR    = (mis & ~dmWe) ? '0 : data_q;
    assign dmBusErr   = err_q;
    assign busWe      = we_q;
    assign busAddr    = addr_q;
    assign busBe      = be_q;
    assign busWData   = wdata_q;

endmodule

// File: tb/tb_sr_lsu.sv
// Directed bench for sr_lsu: lane decode, extension, misalignment, timeout, reset and back-to-back.
module tb_sr_lsu;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        dmRe, dmWe, dmSign, dmOpByte, dmOpHalf, dmOpWord;
    logic [31:0] dmAddr, dmDataW, dmDataR;
    logic        stall, dmMisalign, dmBusErr, busReq, busWe;
    logic [31:0] busAddr, busWData, busRData;
    logic [3:0]  busBe;
    logic        busAck;

    int n_checks = 0;
    int n_fail   = 0;

    sr_lsu #(.ADDR_W(32), .TIMEOUT(3), .TO_W(2)) u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .dmRe       (dmRe),
        .dmWe       (dmWe),
        .dmSign     (dmSign),
        .dmOpByte   (dmOpByte),
        .dmOpHalf   (dmOpHalf),
        .dmOpWord   (dmOpWord),
        .dmAddr     (dmAddr),
        .dmDataW    (dmDataW),
        .dmDataR    (dmDataR),
        .stall      (stall),
        .dmMisalign (dmMisalign),
        .dmBusErr   (dmBusErr),
        .busReq     (busReq),
        .busWe      (busWe),
        .busAddr    (busAddr),
        .busBe      (busBe),
        .busWData   (busWData),
        .busRData   (busRData),
        .busAck     (busAck)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        dmRe = 0; dmWe = 0; dmSign = 0; dmOpByte = 0; dmOpHalf = 0; dmOpWord = 0;
        dmAddr = 0; dmDataW = 0; busRData = 0; busAck = 0;
    endtask

    // Drives one access from the next IDLE cycle until its RESP cycle; returns at the RESP negedge.
    task automatic run_access(input logic re, input logic we, input logic sg, input logic ob,
                              input logic oh, input logic ow, input logic [31:0] addr,
                              input logic [31:0] wd, input logic [31:0] rd, input int ack_at,
                              output int stall_cnt, output int req_cnt, output logic [3:0] be,
                              output logic [31:0] baddr, output logic [31:0] bwd,
                              output logic bwe);
        logic done;
        stall_cnt = 0; req_cnt = 0; be = 0; baddr = 0; bwd = 0; bwe = 0; done = 0;
        @(posedge clk); #1;
        dmRe = re; dmWe = we; dmSign = sg; dmOpByte = ob; dmOpHalf = oh; dmOpWord = ow;
        dmAddr = addr; dmDataW = wd; busRData = rd; busAck = 0;
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge clk);
            if (stall) stall_cnt++;
            if (busReq) begin
                req_cnt++;
                be = busBe; baddr = busAddr; bwd = busWData; bwe = busWe;
            end
            if (!stall && stall_cnt > 0) done = 1;
            busAck = busReq && (req_cnt == ack_at);
        end
        busAck = 0;
        check_eq("access_done", {31'b0, done}, 32'd1);
    endtask

    task automatic check_misalign(input string tag, input logic oh, input logic ow,
                                  input logic [31:0] addr);
        @(posedge clk); #1;
        idle_inputs();
        dmRe = 1; dmOpHalf = oh; dmOpWord = ow; dmAddr = addr;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_eq({tag, "_mis"}, {31'b0, dmMisalign}, 32'd1);
            check_eq({tag, "_stall"}, {31'b0, stall}, 32'd0);
            check_eq({tag, "_req"}, {31'b0, busReq}, 32'd0);
        end
        check_eq({tag, "_data"}, dmDataR, 32'd0);
    endtask

    int          sc, rc;
    logic [3:0]  be;
    logic [31:0] ba, bw;
    logic        bwe;

    initial begin
        idle_inputs();
        rst_n = 0;
        #1;
        check_eq("rst_req", {31'b0, busReq}, 32'd0);
        check_eq("rst_stall", {31'b0, stall}, 32'd0);
        check_eq("rst_addr", busAddr, 32'd0);
        check_eq("rst_be", {28'b0, busBe}, 32'd0);
        check_eq("rst_data", dmDataR, 32'd0);
        check_eq("rst_err", {31'b0, dmBusErr}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1;

        // SW 0xDEADBEEF at 0x10, ack on second REQ cycle
        run_access(0, 1, 0, 0, 0, 1, 32'h10, 32'hDEADBEEF, 0, 2, sc, rc, be, ba, bw, bwe);
        check_eq("sw_stall", sc, 3);
        check_eq("sw_req", rc, 2);
        check_eq("sw_addr", ba, 32'h10);
        check_eq("sw_be", {28'b0, be}, 32'hF);
        check_eq("sw_wdata", bw, 32'hDEADBEEF);
        check_eq("sw_we", {31'b0, bwe}, 32'd1);

        run_access(1, 0, 1, 0, 0, 1, 32'h10, 0, 32'hDEADBEEF, 1, sc, rc, be, ba, bw, bwe);
        check_eq("lw_stall", sc, 2);
        check_eq("lw_we", {31'b0, bwe}, 32'd0);
        check_eq("lw_data", dmDataR, 32'hDEADBEEF);

        run_access(1, 0, 1, 1, 0, 0, 32'h13, 0, 32'h80FF7F01, 1, sc, rc, be, ba, bw, bwe);
        check_eq("lb_be", {28'b0, be}, 32'h8);
        check_eq("lb_addr", ba, 32'h10);
        check_eq("lb_data", dmDataR, 32'hFFFFFF80);

        run_access(1, 0, 0, 1, 0, 0, 32'h13, 0, 32'h80FF7F01, 1, sc, rc, be, ba, bw, bwe);
        check_eq("lbu_data", dmDataR, 32'h00000080);

        run_access(1, 0, 1, 1, 0, 0, 32'h11, 0, 32'h80FF7F01, 1, sc, rc, be, ba, bw, bwe);
        check_eq("lb1_be", {28'b0, be}, 32'h2);
        check_eq("lb1_data", dmDataR, 32'h0000007F);

        run_access(1, 0, 0, 0, 1, 0, 32'h12, 0, 32'h80FF7F01, 1, sc, rc, be, ba, bw, bwe);
        check_eq("lhu_be", {28'b0, be}, 32'hC);
        check_eq("lhu_data", dmDataR, 32'h000080FF);

        run_access(1, 0, 1, 0, 1, 0, 32'h12, 0, 32'h80FF7F01, 1, sc, rc, be, ba, bw, bwe);
        check_eq("lh_data", dmDataR, 32'hFFFF80FF);

        run_access(0, 1, 0, 1, 0, 0, 32'h11, 32'h123456AB, 32'h5A5A5A5A, 1, sc, rc, be, ba, bw, bwe);
        check_eq("sb_be", {28'b0, be}, 32'h2);
        check_eq("sb_wdata", bw, 32'hABABABAB);
        check_eq("sb_addr", ba, 32'h10);
        check_eq("sb_keep", dmDataR, 32'hFFFF80FF);

        run_access(0, 1, 0, 0, 1, 0, 32'h16, 32'h0000BEEF, 0, 1, sc, rc, be, ba, bw, bwe);
        check_eq("sh_be", {28'b0, be}, 32'hC);
        check_eq("sh_wdata", bw, 32'hBEEFBEEF);
        check_eq("sh_addr", ba, 32'h14);

        // Load and store both requested: treated as a store
        run_access(1, 1, 0, 0, 0, 1, 32'h24, 32'h01020304, 32'h99999999, 1, sc, rc, be, ba, bw, bwe);
        check_eq("rw_we", {31'b0, bwe}, 32'd1);
        check_eq("rw_keep", dmDataR, 32'hFFFF80FF);

        // No width strobe: word access
        run_access(1, 0, 0, 0, 0, 0, 32'h28, 0, 32'h11223344, 1, sc, rc, be, ba, bw, bwe);
        check_eq("nostrb_be", {28'b0, be}, 32'hF);
        check_eq("nostrb_data", dmDataR, 32'h11223344);

        check_misalign("mis_lw", 0, 1, 32'h12);
        check_misalign("mis_lh", 1, 0, 32'h11);

        run_access(1, 0, 0, 0, 0, 1, 32'h20, 0, 32'h55555555, 0, sc, rc, be, ba, bw, bwe);
        check_eq("to_req", rc, 3);
        check_eq("to_stall", sc, 4);
        check_eq("to_err", {31'b0, dmBusErr}, 32'd1);
        check_eq("to_data", dmDataR, 32'd0);

        run_access(1, 0, 1, 0, 1, 0, 32'h22, 0, 32'h80010000, 1, sc, rc, be, ba, bw, bwe);
        check_eq("rec_err", {31'b0, dmBusErr}, 32'd0);
        check_eq("rec_data", dmDataR, 32'hFFFF8001);

        run_access(1, 0, 0, 0, 0, 1, 32'h40, 0, 32'hCAFEF00D, 1, sc, rc, be, ba, bw, bwe);
        check_eq("b2b_lw_stall", sc, 2);
        check_eq("b2b_lw_req", rc, 1);
        check_eq("b2b_lw_data", dmDataR, 32'hCAFEF00D);
        run_access(0, 1, 0, 0, 0, 1, 32'h44, 32'h0BADCAFE, 0, 1, sc, rc, be, ba, bw, bwe);
        check_eq("b2b_sw_stall", sc, 2);
        check_eq("b2b_sw_req", rc, 1);
        check_eq("b2b_sw_addr", ba, 32'h44);

        // Reset while REQ is outstanding
        @(posedge clk); #1;
        idle_inputs();
        dmRe = 1; dmOpWord = 1; dmAddr = 32'h30; busRData = 32'h77777777;
        @(negedge clk);
        @(negedge clk);
        check_eq("mid_req", {31'b0, busReq}, 32'd1);
        rst_n = 0;
        idle_inputs();
        #1;
        check_eq("mid_rst_req", {31'b0, busReq}, 32'd0);
        check_eq("mid_rst_stall", {31'b0, stall}, 32'd0);
        check_eq("mid_rst_addr", busAddr, 32'd0);
        check_eq("mid_rst_wdata", busWData, 32'd0);
        check_eq("mid_rst_data", dmDataR, 32'd0);
        @(negedge clk);
        rst_n = 1;
        busRData = 32'h77777777;
        @(negedge clk);
        busAck = 1;
        @(negedge clk);
        busAck = 0;
        check_eq("late_ack_req", {31'b0, busReq}, 32'd0);
        check_eq("late_ack_stall", {31'b0, stall}, 32'd0);
        check_eq("late_ack_data", dmDataR, 32'd0);
        @(negedge clk);
        check_eq("late_ack_req2", {31'b0, busReq}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
